coin_dispense_sequencer: RTL and testbench

COIN_DISPENSE_SEQUENCER -- requirements
Module: coin_dispense_sequencer

---
 rtl/coin_dispense_sequencer_pkg.sv | 18 +
 rtl/coin_dispense_sequencer_timer.sv | 36 +++
 rtl/coin_dispense_sequencer.sv | 129 ++++++++++++
 tb/tb_coin_dispense_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/coin_dispense_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// coin_dispense_sequencer_pkg
// Shared definitions for the coin dispenser: sequencer state encoding and the
// servo position codes understood by the servo PWM stage.
// -----------------------------------------------------------------------------
package coin_dispense_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PUSH   = 2'd1,
        S_RETURN = 2'd2,
        S_DONE   = 2'd3
    } seq_state_t;

    localparam logic [31:0] SERVO_REST = 32'd0;
    localparam logic [31:0] SERVO_PUSH = 32'd1;

endpackage

// File: rtl/coin_dispense_sequencer_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Down-counting dwell timer. Loaded with (dwell-1) on state entry; expired is
// high while the count reads zero, and the count then holds at zero.
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-high clear (count -> 0)
//   load       load load_value on the next rising edge
//   load_value value to load (dwell cycles minus one)
//   expired    count is zero
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// coin_dispense_sequencer
// Dispenses coin_count coins by cycling a servo between push and rest
// positions, holding each position for a fixed number of clock cycles.
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   start       dispense request, sampled only while idle
//   coin_count  coins to dispense, captured when start is accepted
//   servoCtrl   registered servo position code (SERVO_REST / SERVO_PUSH)
//   busy        high in every state except idle
//   done        one-cycle completion pulse
//   coins_left  coins remaining in the current request
// -----------------------------------------------------------------------------
module coin_dispense_sequencer
    import coin_dispense_sequencer_pkg::*;
#(
    parameter int unsigned PUSH_CYCLES   = 50_000_000,
    parameter int unsigned RETURN_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  coin_count,
    output logic [31:0] servoCtrl,
    output logic        busy,
    output logic        done,
    output logic [3:0]  coins_left
);

    // Timer only ever holds (dwell-1), so clog2 of the longer dwell suffices.
    localparam int unsigned DWELL_MAX = (PUSH_CYCLES > RETURN_CYCLES) ? PUSH_CYCLES : RETURN_CYCLES;
    localparam int unsigned TIMER_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam logic [TIMER_W-1:0] PUSH_LOAD   = TIMER_W'(PUSH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RETURN_LOAD = TIMER_W'(RETURN_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_value;
    logic               w_expired;
    logic [3:0]         r_coins_left;
    logic [3:0]         w_coins_dec;
    logic [31:0]        r_servo;
    logic               r_busy;
    logic               r_done;

    assign w_coins_dec = r_coins_left - 4'd1;

    dwell_timer #(
        .WIDTH (TIMER_W)
    ) u_dwell_timer (
        .clk        (clk),
        .clr        (clr),
        .load       (w_load),
        .load_value (w_load_value),
        .expired    (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_value = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (coin_count != 4'd0) begin
                        w_next       = S_PUSH;
                        w_load       = 1'b1;
                        w_load_value = PUSH_LOAD;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_PUSH: begin
                if (w_expired) begin
                    w_next       = S_RETURN;
                    w_load       = 1'b1;
                    w_load_value = RETURN_LOAD;
                end
            end
            S_RETURN: begin
                if (w_expired) begin
                    if (w_coins_dec != 4'd0) begin
                        w_next       = S_PUSH;
                        w_load       = 1'b1;
                        w_load_value = PUSH_LOAD;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_coins_left <= '0;
            r_servo      <= SERVO_REST;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_servo <= (w_next == S_PUSH) ? SERVO_PUSH : SERVO_REST;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_coins_left <= coin_count;
            end else if (r_state == S_RETURN && w_expired) begin
                r_coins_left <= w_coins_dec;
            end
        end
    end

    assign servoCtrl  = r_servo;
    assign busy       = r_busy;
    assign done       = r_done;
    assign coins_left = r_coins_left;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coin_dispense_sequencer
// Self-checking bench: directed scenarios plus random start/coin_count/clr,
// compared every cycle against a queue-based reference of expected outputs.
// -----------------------------------------------------------------------------
module tb_coin_dispense_sequencer;

    localparam int unsigned P = 4;
    localparam int unsigned R = 3;

    typedef struct {
        logic [31:0] servo;
        logic        busy;
        logic        done;
        logic [3:0]  left;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  coin_count = '0;
    logic [31:0] servoCtrl;
    logic        busy;
    logic        done;
    logic [3:0]  coins_left;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned busy_cnt = 0;
    int unsigned pulse_cnt = 0;
    logic [31:0] prev_servo = '0;

    exp_t cur;
    exp_t exp_q[$];

    coin_dispense_sequencer #(
        .PUSH_CYCLES   (P),
        .RETURN_CYCLES (R)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .coin_count (coin_count),
        .servoCtrl  (servoCtrl),
        .busy       (busy),
        .done       (done),
        .coins_left (coins_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.servo = 32'd0;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.left  = 4'd0;
        return e;
    endfunction

    // A request for n coins is the sequence: per coin, P push cycles then R
    // rest cycles (coins_left = coins still owed), then one done cycle.
    task automatic model_accept(input logic [3:0] n);
        exp_t e;
        for (int k = int'(n); k >= 1; k--) begin
            for (int c = 0; c < int'(P + R); c++) begin
                e.servo = (c < int'(P)) ? 32'd1 : 32'd0;
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.left  = 4'(k);
                exp_q.push_back(e);
            end
        end
        e.servo = 32'd0;
        e.busy  = 1'b1;
        e.done  = 1'b1;
        e.left  = 4'd0;
        exp_q.push_back(e);
    endtask

    task automatic model_edge();
        if (!cur.busy && start) model_accept(coin_count);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = idle_exp();
    endtask

    task automatic compare_all();
        check("servoCtrl", servoCtrl, cur.servo);
        check("busy", {31'd0, busy}, {31'd0, cur.busy});
        check("done", {31'd0, done}, {31'd0, cur.done});
        check("coins_left", {28'd0, coins_left}, {28'd0, cur.left});
        busy_cnt += int'(busy);
        if (servoCtrl == 32'd1 && prev_servo == 32'd0) pulse_cnt++;
        prev_servo = servoCtrl;
    endtask

    task automatic cycle(input logic s, input logic [3:0] n);
        @(negedge clk);
        start      = s;
        coin_count = n;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous clear pulse placed between clock edges.
    task automatic clr_pulse();
        @(negedge clk);
        start = 1'b0;
        #1 clr = 1'b1;
        exp_q.delete();
        cur = idle_exp();
        #1 compare_all();
        #1 clr = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 4'd0);
    endtask

    initial begin
        cur = idle_exp();
        repeat (3) @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        clr = 1'b0;

        // Two coins: 15 busy cycles, two push pulses.
        busy_cnt = 0; pulse_cnt = 0;
        cycle(1'b1, 4'd2);
        idle(20);
        check("busy_len_n2", busy_cnt, 15);
        check("pulses_n2", pulse_cnt, 2);

        // Zero coins: straight to done, one busy cycle.
        busy_cnt = 0; pulse_cnt = 0;
        cycle(1'b1, 4'd0);
        idle(4);
        check("busy_len_n0", busy_cnt, 1);
        check("pulses_n0", pulse_cnt, 0);

        // Held start retriggers only from idle.
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'd1);
        idle(10);

        // coin_count changes after acceptance are ignored.
        pulse_cnt = 0;
        cycle(1'b1, 4'd3);
        for (int i = 0; i < 30; i++) cycle(1'b0, 4'd1);
        check("pulses_n3_change", pulse_cnt, 3);

        // Clear during the second push of a three-coin request.
        cycle(1'b1, 4'd3);
        idle(8);
        clr_pulse();
        idle(3);
        busy_cnt = 0;
        cycle(1'b1, 4'd1);
        idle(12);
        check("busy_len_after_clr", busy_cnt, 8);

        // Fifteen coins: 106 busy cycles, 15 pulses.
        busy_cnt = 0; pulse_cnt = 0;
        cycle(1'b1, 4'd15);
        idle(110);
        check("busy_len_n15", busy_cnt, 106);
        check("pulses_n15", pulse_cnt, 15);

        // Random traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) clr_pulse();
            else cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15) & (($urandom_range(0, 1) == 1) ? 3 : 15)));
        end
        idle(120);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
